pe_mac_lane_v2: RTL and testbench

//  Next-generation processing element: a weight pad, a 2-stage MAC pipeline and ROWS psum accumulators.

---
 rtl/pe_mac_lane_v2.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_pe_mac_lane_v2.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_lane_v2.sv
// pe_mac_lane_v2: weight pad, 2-stage MAC pipeline and ROWS psum accumulators under a LOAD/RUN/DRAIN/OUT job FSM.
// Optional left-PE psum chaining on the output port is enabled by defining PE_LPE_CHAIN_EN.
module pe_mac_lane_v2 #(
  parameter int ROWS    = 16,
  parameter int IPADN   = 4,
  parameter int DWD     = 8,
  parameter int PSUMDWD = 24,
  parameter int KMAX    = 16,
  parameter int NMAXWD  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [$clog2(KMAX+1)-1:0]    i_cfg_klen,
  input  logic [NMAXWD-1:0]            i_cfg_nout,
  input  logic                         i_cfg_signed,
  input  logic                         i_cfg_sat,
  input  logic                         Weight_rdy,
  output logic                         Weight_ack,
  input  logic [ROWS-1:0][DWD-1:0]     i_Weight,
  input  logic                         Input_rdy,
  output logic                         Input_ack,
  input  logic [IPADN-1:0][DWD-1:0]    i_Input,
  input  logic                         LPE_rdy,
  output logic                         LPE_ack,
  input  logic [ROWS-1:0][PSUMDWD-1:0] i_Psum_LPE,
  output logic                         POUT_rdy,
  input  logic                         POUT_ack,
  output logic [ROWS-1:0][PSUMDWD-1:0] o_Psum,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int KW  = $clog2(KMAX + 1);
  localparam int KIW = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int PW  = 2 * DWD;
  localparam int RPI = ROWS / IPADN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  function automatic logic [PW-1:0] mul_fn(input logic [DWD-1:0] a, input logic [DWD-1:0] b,
                                           input logic sgn);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    if (sgn) begin
      ea = PW'($signed(a));
      eb = PW'($signed(b));
    end else begin
      ea = PW'(a);
      eb = PW'(b);
    end
    return ea * eb;
  endfunction

  function automatic logic [PSUMDWD-1:0] ext_fn(input logic [PW-1:0] p, input logic sgn);
    logic [PSUMDWD-1:0] e;
    if (sgn) begin
      e = PSUMDWD'($signed(p));
    end else begin
      e = PSUMDWD'(p);
    end
    return e;
  endfunction

  // Overflow is detected on the operand/result signs (signed) or the carry-out (unsigned).
  function automatic logic [PSUMDWD-1:0] add_fn(input logic [PSUMDWD-1:0] a, input logic [PSUMDWD-1:0] b,
                                                input logic sgn, input logic sat);
    logic [PSUMDWD:0]   s;
    logic [PSUMDWD-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = s[PSUMDWD-1:0];
    if (!sat) begin
      r = s[PSUMDWD-1:0];
    end else if (sgn) begin
      if ((a[PSUMDWD-1] == b[PSUMDWD-1]) && (r[PSUMDWD-1] != a[PSUMDWD-1])) begin
        r = a[PSUMDWD-1] ? {1'b1, {(PSUMDWD-1){1'b0}}} : {1'b0, {(PSUMDWD-1){1'b1}}};
      end else begin
        r = s[PSUMDWD-1:0];
      end
    end else begin
      if (s[PSUMDWD]) begin
        r = {PSUMDWD{1'b1}};
      end else begin
        r = s[PSUMDWD-1:0];
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [KW-1:0]      kcnt_q, kcnt_d;
  logic [KW-1:0]      klen_q, klen_d;
  logic [NMAXWD-1:0]  nleft_q, nleft_d;
  logic               sgn_q, sgn_d;
  logic               sat_q, sat_d;
  logic               done_q, done_d;
  logic               s1_vld_q, s1_first_q;

  logic [KW-1:0]      klen_cfg_s;
  logic [KIW-1:0]     kidx_s;
  logic               kcnt_last_s;
  logic               w_xfer_s, in_xfer_s, out_xfer_s;

  logic [ROWS-1:0][DWD-1:0] pad_q [KMAX];

  assign kidx_s      = kcnt_q[KIW-1:0];
  assign kcnt_last_s = (kcnt_q == (klen_q - KW'(1)));
  assign w_xfer_s    = Weight_rdy & Weight_ack;
  assign in_xfer_s   = Input_rdy & Input_ack;
  assign out_xfer_s  = POUT_rdy & POUT_ack;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;

  // Normalise the requested accumulation length into 1..KMAX
  always_comb begin
    klen_cfg_s = i_cfg_klen;
    if (i_cfg_klen == {KW{1'b0}}) begin
      klen_cfg_s = KW'(1);
    end else if (i_cfg_klen > KW'(KMAX)) begin
      klen_cfg_s = KW'(KMAX);
    end else begin
      klen_cfg_s = i_cfg_klen;
    end
  end

  // Channel handshakes: each sink acks only in the state that consumes it
  always_comb begin
    Weight_ack = 1'b0;
    Input_ack  = 1'b0;
    POUT_rdy   = 1'b0;
    LPE_ack    = 1'b0;
    case (state_q)
      S_LOAD: Weight_ack = Weight_rdy;
      S_RUN:  Input_ack  = Input_rdy;
      S_OUT: begin
`ifdef PE_LPE_CHAIN_EN
        POUT_rdy = LPE_rdy;
        LPE_ack  = LPE_rdy & POUT_ack;
`else
        POUT_rdy = 1'b1;
`endif
      end
      default: begin
        Weight_ack = 1'b0;
      end
    endcase
  end

  // Job FSM next state; kcnt doubles as pad address, beat index and drain timer
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    klen_d  = klen_q;
    nleft_d = nleft_q;
    sgn_d   = sgn_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LOAD;
          kcnt_d  = {KW{1'b0}};
          klen_d  = klen_cfg_s;
          nleft_d = (i_cfg_nout == {NMAXWD{1'b0}}) ? NMAXWD'(1) : i_cfg_nout;
          sgn_d   = i_cfg_signed;
          sat_d   = i_cfg_sat;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD, S_RUN: begin
        if ((state_q == S_LOAD) ? w_xfer_s : in_xfer_s) begin
          if (kcnt_last_s) begin
            kcnt_d  = {KW{1'b0}};
            state_d = (state_q == S_LOAD) ? S_RUN : S_DRAIN;
          end else begin
            kcnt_d  = kcnt_q + KW'(1);
          end
        end else begin
          kcnt_d = kcnt_q;
        end
      end
      S_DRAIN: begin
        if (kcnt_q == KW'(1)) begin
          kcnt_d  = {KW{1'b0}};
          state_d = S_OUT;
        end else begin
          kcnt_d  = kcnt_q + KW'(1);
        end
      end
      S_OUT: begin
        if (out_xfer_s) begin
          if (nleft_q == NMAXWD'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
          nleft_d = nleft_q - NMAXWD'(1);
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      kcnt_q     <= {KW{1'b0}};
      klen_q     <= KW'(1);
      nleft_q    <= {NMAXWD{1'b0}};
      sgn_q      <= 1'b0;
      sat_q      <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kcnt_q     <= kcnt_d;
      klen_q     <= klen_d;
      nleft_q    <= nleft_d;
      sgn_q      <= sgn_d;
      sat_q      <= sat_d;
      done_q     <= done_d;
      s1_vld_q   <= in_xfer_s;
      s1_first_q <= in_xfer_s & (kcnt_q == {KW{1'b0}});
    end
  end

  // Weight pad storage; contents are only meaningful after LOAD
  always_ff @(posedge i_clk) begin
    if (w_xfer_s) begin
      pad_q[kidx_s] <= i_Weight;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [PW-1:0]      prod_q;
    logic [PSUMDWD-1:0] acc_q;
    logic [PSUMDWD-1:0] ext_s;

    assign ext_s = ext_fn(prod_q, sgn_q);

    // S1 product register and S2 accumulator; the first beat of an output overwrites
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        prod_q <= {PW{1'b0}};
        acc_q  <= {PSUMDWD{1'b0}};
      end else begin
        if (in_xfer_s) begin
          prod_q <= mul_fn(pad_q[kidx_s][r], i_Input[r / RPI], sgn_q);
        end else begin
          prod_q <= prod_q;
        end
        if (s1_vld_q) begin
          acc_q <= s1_first_q ? ext_s : add_fn(acc_q, ext_s, sgn_q, sat_q);
        end else if (out_xfer_s) begin
          acc_q <= {PSUMDWD{1'b0}};
        end else begin
          acc_q <= acc_q;
        end
      end
    end

`ifdef PE_LPE_CHAIN_EN
    assign o_Psum[r] = (state_q == S_OUT) ? add_fn(acc_q, i_Psum_LPE[r], sgn_q, sat_q) : acc_q;
`else
    assign o_Psum[r] = acc_q;
`endif
  end

`ifndef PE_LPE_CHAIN_EN
  logic lpe_unused;
  assign lpe_unused = ^{LPE_rdy, i_Psum_LPE};
`endif

endmodule

// File: tb/tb_pe_mac_lane_v2.sv
// Self-checking bench for pe_mac_lane_v2 (PSUMDWD=16): randomized jobs against an arithmetic reference model.
module tb_pe_mac_lane_v2;

  localparam int ROWS   = 16;
  localparam int IPADN  = 4;
  localparam int DWD    = 8;
  localparam int P      = 16;
  localparam int KMAX   = 16;
  localparam int NMAXWD = 8;
  localparam int KW     = $clog2(KMAX + 1);
  localparam int RPI    = ROWS / IPADN;
  localparam int NOM    = 4;
`ifdef PE_LPE_CHAIN_EN
  localparam bit CHAIN  = 1'b1;
`else
  localparam bit CHAIN  = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_rst, i_start, i_cfg_signed, i_cfg_sat;
  logic [KW-1:0] i_cfg_klen;
  logic [NMAXWD-1:0] i_cfg_nout;
  logic Weight_rdy, Weight_ack, Input_rdy, Input_ack, LPE_rdy, LPE_ack, POUT_rdy, POUT_ack;
  logic o_busy, o_done;
  logic [ROWS-1:0][DWD-1:0] i_Weight;
  logic [IPADN-1:0][DWD-1:0] i_Input;
  logic [ROWS-1:0][P-1:0] i_Psum_LPE;
  logic [ROWS-1:0][P-1:0] o_Psum;

  int vectors = 0;
  int miscompares = 0;

  int     wt[KMAX][ROWS];
  int     inp[NOM][KMAX][IPADN];
  longint lpe[ROWS];
  logic [P-1:0] obs[NOM][ROWS];
  logic [P-1:0] expv[NOM][ROWS];
  logic lpe_ack_obs[NOM];
  int wbad, inack_bad, stable_bad, lpe_bad, timeouts;
  logic done_obs, done_after, busy_after;

  pe_mac_lane_v2 #(.ROWS(ROWS), .IPADN(IPADN), .DWD(DWD), .PSUMDWD(P), .KMAX(KMAX), .NMAXWD(NMAXWD)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_cfg_klen(i_cfg_klen), .i_cfg_nout(i_cfg_nout),
    .i_cfg_signed(i_cfg_signed), .i_cfg_sat(i_cfg_sat),
    .Weight_rdy(Weight_rdy), .Weight_ack(Weight_ack), .i_Weight(i_Weight),
    .Input_rdy(Input_rdy), .Input_ack(Input_ack), .i_Input(i_Input),
    .LPE_rdy(LPE_rdy), .LPE_ack(LPE_ack), .i_Psum_LPE(i_Psum_LPE),
    .POUT_rdy(POUT_rdy), .POUT_ack(POUT_ack), .o_Psum(o_Psum), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sval(longint x, int w, bit sg);
    longint m;
    m = longint'(1) << w;
    if (sg && x >= m / 2) return x - m;
    return x;
  endfunction

  function automatic longint fold(longint v, bit sg, bit st);
    longint m, lo, hi;
    m = longint'(1) << P;
    if (st) begin
      lo = sg ? -(m / 2) : 0;
      hi = sg ? (m / 2 - 1) : (m - 1);
      if (v < lo) v = lo;
      if (v > hi) v = hi;
    end else begin
      v = v % m;
      if (v < 0) v = v + m;
      if (sg && v >= m / 2) v = v - m;
    end
    return v;
  endfunction

  task automatic compute_expected(input int keff, input int neff, input bit sg, input bit st);
    longint acc, p, e;
    for (int n = 0; n < neff; n++) begin
      for (int r = 0; r < ROWS; r++) begin
        acc = 0;
        for (int k = 0; k < keff; k++) begin
          p   = sval(wt[k][r], DWD, sg) * sval(inp[n][k][r / RPI], DWD, sg);
          acc = fold((k == 0) ? p : acc + p, sg, st);
        end
        e = CHAIN ? fold(acc + sval(lpe[r], P, sg), sg, st) : acc;
        expv[n][r] = e[P-1:0];
      end
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < KMAX; k++) for (int r = 0; r < ROWS; r++) wt[k][r] = $urandom_range(0, 255);
    for (int n = 0; n < NOM; n++) for (int k = 0; k < KMAX; k++) for (int g = 0; g < IPADN; g++)
      inp[n][k][g] = $urandom_range(0, 255);
    for (int r = 0; r < ROWS; r++) lpe[r] = $urandom_range(0, 65535);
  endtask

  task automatic fill_const(input int wv, input int iv);
    for (int k = 0; k < KMAX; k++) for (int r = 0; r < ROWS; r++) wt[k][r] = wv;
    for (int n = 0; n < NOM; n++) for (int k = 0; k < KMAX; k++) for (int g = 0; g < IPADN; g++) inp[n][k][g] = iv;
    for (int r = 0; r < ROWS; r++) lpe[r] = 0;
  endtask

  task automatic run_job(input int kc, input int nc, input bit sg, input bit st, input bit gaps,
                         input int pout_hold, input int lpe_hold);
    int keff, neff, k, cyc;
    keff = (kc == 0) ? 1 : ((kc > KMAX) ? KMAX : kc);
    neff = (nc == 0) ? 1 : nc;
    wbad = 0; inack_bad = 0; stable_bad = 0; lpe_bad = 0; timeouts = 0;
    for (int n = 0; n < NOM; n++) lpe_ack_obs[n] = 1'b0;
    for (int r = 0; r < ROWS; r++) i_Psum_LPE[r] = lpe[r][P-1:0];
    i_cfg_klen = KW'(kc); i_cfg_nout = NMAXWD'(nc); i_cfg_signed = sg; i_cfg_sat = st;
    LPE_rdy = 1'b1;
    i_start = 1'b1; tick; i_start = 1'b0;
    k = 0; cyc = 0;
    while (k < keff && cyc < 400) begin
      Weight_rdy = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int r = 0; r < ROWS; r++) i_Weight[r] = DWD'(wt[k][r]);
      #1; if (Weight_rdy && Weight_ack) k++;
      tick; cyc++;
    end
    if (k < keff) timeouts++;
    for (int n = 0; n < neff; n++) begin
      k = 0; cyc = 0;
      while (k < keff && cyc < 400) begin
        Weight_rdy = 1'b1;
        Input_rdy  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int g = 0; g < IPADN; g++) i_Input[g] = DWD'(inp[n][k][g]);
        #1; if (Weight_ack) wbad++;
        if (Input_rdy && Input_ack) k++;
        tick; cyc++;
      end
      if (k < keff) timeouts++;
      Input_rdy = 1'b1;
      for (int g = 0; g < IPADN; g++) i_Input[g] = DWD'($urandom_range(0, 255));
      LPE_rdy = (lpe_hold == 0);
      for (int h = 0; h < lpe_hold; h++) begin
        #1; if (POUT_rdy) lpe_bad++;
        if (Input_ack) inack_bad++;
        tick;
      end
      LPE_rdy = 1'b1;
      cyc = 0;
      #1;
      while (!POUT_rdy && cyc < 40) begin
        if (Input_ack) inack_bad++;
        tick; #1; cyc++;
      end
      if (!POUT_rdy) timeouts++;
      for (int r = 0; r < ROWS; r++) obs[n][r] = o_Psum[r];
      for (int h = 0; h < pout_hold; h++) begin
        tick; #1;
        if (Input_ack) inack_bad++;
        if (!POUT_rdy) stable_bad++;
        for (int r = 0; r < ROWS; r++) if (o_Psum[r] !== obs[n][r]) stable_bad++;
      end
      POUT_ack = 1'b1; Input_rdy = 1'b0;
      #1; lpe_ack_obs[n] = LPE_ack;
      tick; POUT_ack = 1'b0;
    end
    Weight_rdy = 1'b0;
    done_obs = o_done; busy_after = o_busy;
    tick; done_after = o_done;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_cfg_klen = '0; i_cfg_nout = '0; i_cfg_signed = 1'b0; i_cfg_sat = 1'b0;
    Weight_rdy = 1'b1; Input_rdy = 1'b1; LPE_rdy = 1'b1; POUT_ack = 1'b1;
    i_Weight = '0; i_Input = '0; i_Psum_LPE = '0;
    tick; tick;
    vectors++;
    if ({Weight_ack, Input_ack, LPE_ack, POUT_rdy, o_busy, o_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000", {Weight_ack, Input_ack, LPE_ack, POUT_rdy, o_busy, o_done});
    end
    vectors++;
    if (o_Psum !== '0) begin miscompares++; $display("FAIL reset_psum: got %h expected 0", o_Psum); end
    i_rst = 1'b0; Weight_rdy = 1'b0; Input_rdy = 1'b0; POUT_ack = 1'b0;
    tick;
  endtask

  task automatic test_basic();
    fill_const(2, 3);
    run_job(4, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== 16'd24) begin miscompares++; $display("FAIL basic row%0d: got %0d expected 24", r, obs[0][r]); end
    end
    vectors++;
    if ({done_obs, done_after, busy_after, timeouts != 0} !== 4'b1000) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b next=%b busy=%b to=%0d expected 1 0 0 0", done_obs, done_after, busy_after, timeouts);
    end
  endtask

  task automatic test_signed();
    fill_const(255, 5);
    run_job(3, 1, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== 16'hFFF1) begin miscompares++; $display("FAIL signed row%0d: got %h expected fff1", r, obs[0][r]); end
    end
    run_job(3, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== 16'd3825) begin miscompares++; $display("FAIL unsigned row%0d: got %0d expected 3825", r, obs[0][r]); end
    end
  endtask

  task automatic test_sat_wrap();
    fill_const(127, 127);
    run_job(8, 1, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== 16'd32767) begin miscompares++; $display("FAIL sat row%0d: got %0d expected 32767", r, obs[0][r]); end
    end
    run_job(8, 1, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== 16'hF808) begin miscompares++; $display("FAIL wrap row%0d: got %h expected f808", r, obs[0][r]); end
    end
  endtask

  task automatic test_reuse();
    fill_const(0, 0);
    for (int r = 0; r < ROWS; r++) begin wt[0][r] = 1; wt[1][r] = 2; end
    for (int n = 0; n < 3; n++) for (int k = 0; k < 2; k++) for (int g = 0; g < IPADN; g++) inp[n][k][g] = n + 1;
    run_job(2, 3, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int n = 0; n < 3; n++) for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[n][r] !== 16'(3 * (n + 1))) begin
        miscompares++; $display("FAIL reuse out%0d row%0d: got %0d expected %0d", n, r, obs[n][r], 3 * (n + 1));
      end
    end
    vectors++;
    if (wbad !== 0) begin miscompares++; $display("FAIL reuse_wack: got %0d acks after LOAD expected 0", wbad); end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_job(5, 2, 1'b1, 1'b0, 1'b1, 10, 0);
    compute_expected(5, 2, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[n][r] !== expv[n][r]) begin
        miscompares++; $display("FAIL bp out%0d row%0d: got %h expected %h", n, r, obs[n][r], expv[n][r]);
      end
    end
    vectors++;
    if (stable_bad !== 0 || inack_bad !== 0) begin
      miscompares++; $display("FAIL bp_hold: got unstable=%0d input_acks=%0d expected 0 0", stable_bad, inack_bad);
    end
  endtask

  task automatic test_reset_mid_run();
    fill_random();
    i_cfg_klen = KW'(3); i_cfg_nout = NMAXWD'(1); i_cfg_signed = 1'b0; i_cfg_sat = 1'b0;
    i_start = 1'b1; tick; i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Weight_rdy = 1'b1;
      for (int r = 0; r < ROWS; r++) i_Weight[r] = DWD'(wt[k][r]);
      tick;
    end
    Weight_rdy = 1'b0; Input_rdy = 1'b1; i_Input = {IPADN{8'hFF}};
    tick; tick;
    i_rst = 1'b1; tick; i_rst = 1'b0;
    #1;
    vectors++;
    if ({o_busy, Input_ack, POUT_rdy} !== 3'b000 || o_Psum !== '0) begin
      miscompares++; $display("FAIL abort: got busy=%b iack=%b prdy=%b psum=%h expected 0", o_busy, Input_ack, POUT_rdy, o_Psum);
    end
    tick; #1;
    vectors++;
    if (o_Psum !== '0) begin miscompares++; $display("FAIL abort_inflight: got %h expected 0", o_Psum); end
    Input_rdy = 1'b0; tick;
    run_job(4, 1, 1'b0, 1'b1, 1'b1, 0, 0);
    compute_expected(4, 1, 1'b0, 1'b1);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== expv[0][r]) begin
        miscompares++; $display("FAIL after_abort row%0d: got %h expected %h", r, obs[0][r], expv[0][r]);
      end
    end
  endtask

  task automatic test_random_jobs();
    int kc, nc, neff, keff;
    bit sg, st;
    for (int j = 0; j < 8; j++) begin
      fill_random();
      case (j)
        0: begin kc = 0;  nc = 0; end
        1: begin kc = 31; nc = 1; end
        2: begin kc = 16; nc = 2; end
        default: begin kc = $urandom_range(0, KMAX + 4); nc = $urandom_range(0, 3); end
      endcase
      sg = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
      keff = (kc == 0) ? 1 : ((kc > KMAX) ? KMAX : kc);
      neff = (nc == 0) ? 1 : nc;
      run_job(kc, nc, sg, st, 1'b1, $urandom_range(0, 3), 0);
      compute_expected(keff, neff, sg, st);
      for (int n = 0; n < neff; n++) for (int r = 0; r < ROWS; r++) begin
        vectors++;
        if (obs[n][r] !== expv[n][r]) begin
          miscompares++;
          $display("FAIL rand job%0d k%0d s%0b t%0b out%0d row%0d: got %h expected %h", j, kc, sg, st, n, r, obs[n][r], expv[n][r]);
        end
      end
      vectors++;
      if (timeouts !== 0 || done_obs !== 1'b1) begin
        miscompares++; $display("FAIL rand_flow job%0d: got timeouts=%0d done=%b expected 0 1", j, timeouts, done_obs);
      end
    end
  endtask

  task automatic test_lpe();
`ifdef PE_LPE_CHAIN_EN
    fill_const(2, 3);
    for (int r = 0; r < ROWS; r++) lpe[r] = 100;
    run_job(4, 1, 1'b0, 1'b0, 1'b0, 0, 6);
    for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[0][r] !== 16'd124) begin miscompares++; $display("FAIL chain row%0d: got %0d expected 124", r, obs[0][r]); end
    end
    vectors++;
    if (lpe_bad !== 0 || lpe_ack_obs[0] !== 1'b1) begin
      miscompares++; $display("FAIL chain_hs: got prdy_while_lpe_low=%0d lpe_ack=%b expected 0 1", lpe_bad, lpe_ack_obs[0]);
    end
`else
    fill_random();
    run_job(6, 2, 1'b1, 1'b1, 1'b1, 0, 0);
    compute_expected(6, 2, 1'b1, 1'b1);
    for (int n = 0; n < 2; n++) for (int r = 0; r < ROWS; r++) begin
      vectors++;
      if (obs[n][r] !== expv[n][r]) begin
        miscompares++; $display("FAIL lpe_ignored out%0d row%0d: got %h expected %h", n, r, obs[n][r], expv[n][r]);
      end
    end
    vectors++;
    if (lpe_ack_obs[0] !== 1'b0 || lpe_ack_obs[1] !== 1'b0) begin
      miscompares++; $display("FAIL lpe_ack_tied: got %b%b expected 00", lpe_ack_obs[0], lpe_ack_obs[1]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_sat_wrap();
    test_reuse();
    test_backpressure();
    test_reset_mid_run();
    test_random_jobs();
    test_lpe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
